atm_light_estimator: RTL and testbench
======================================

ATM_LIGHT_ESTIMATOR -- requirements
Module: atm_light_estimator

Interface
REQ-001: Parameter IMG_WIDTH, default 512, image width in pixels.
REQ-002: Parameter IMG_HEIGHT, default 512, image height in pixels; frame length N = IMG_WIDTH*IMG_HEIGHT.
REQ-003: clk  input  1  clock; all state changes on rising edge.
REQ-004: rst  input  1  reset, synchronous, active-high.
REQ-005: input_pixel  input  24  pixel, R=[23:16], G=[15:8], B=[7:0].
REQ-006: input_is_valid  input  1  input_pixel accepted on any rising edge where high, except in DONE or during restart.
REQ-007: restart  input  1  single-cycle pulse; discards the estimate and arms a new frame.
REQ-008: A_R, A_G, A_B  output  8 each  atmospheric light estimate, registered.
REQ-009: dark_max  output  8  largest per-pixel dark channel seen in the frame, registered.
REQ-010: ale_done  output  1  level; high while A_R/A_G/A_B hold the final estimate for the frame.

Function
REQ-011: The dark channel of a pixel is min(R,G,B), 8-bit unsigned, computed in pipeline stage 1 (registered together with the RGB value).
REQ-012: Stage 2 compares the stage-1 dark value with the running maximum and updates the maximum and candidate RGB only on strictly greater; ties keep the earliest pixel.
REQ-013: The running maximum starts at 0, and the candidate starts at RGB 0/0/0, at frame start.
REQ-014: FSM states: IDLE, ACCUM, FLUSH, DONE; reset state IDLE.
REQ-015: IDLE->ACCUM on the first accepted pixel; that pixel counts as pixel 0.
REQ-016: ACCUM: 18-bit-minimum pixel counter increments per accepted pixel; gaps in input_is_valid hold counter and pipeline contents without loss.
REQ-017: ACCUM->FLUSH on acceptance of pixel N-1; FLUSH lasts 1 cycle to drain stage 2; FLUSH->DONE unconditionally.
REQ-018: Latency: last pixel accepted at edge E; ale_done=1 and final A/dark_max visible after edge E+2.
REQ-019: On entry to DONE, A_R/A_G/A_B = candidate channels, each floored to 1 (value 0 -> 1), so downstream division is never by zero; dark_max is unfloored.
REQ-020: DONE: outputs held constant and input_is_valid ignored (second pass of the same image must not disturb A) until restart or rst.
REQ-021: A_R/A_G/A_B/dark_max are only updated on the FLUSH->DONE transition; during IDLE/ACCUM/FLUSH they retain their previous values.
REQ-022: restart in any state: next state IDLE, counter, running maximum and candidate cleared, ale_done=0 next cycle; A outputs retain their values.
REQ-023: restart and input_is_valid in the same cycle: restart wins, pixel dropped and not counted.
REQ-024: Pixels arriving in FLUSH are ignored.

Reset
REQ-025: rst forces, on the next edge: state IDLE, counter 0, running max 0, candidate 0, pipeline valid flags 0, A_R=A_G=A_B=0, dark_max=0, ale_done=0.
REQ-026: rst mid-frame (any state) abandons the frame; behaviour afterwards is identical to power-up reset.
REQ-027: rst has priority over restart and input_is_valid.

Verification (IMG_WIDTH=4, IMG_HEIGHT=2, N=8 unless noted)
REQ-028: 8 back-to-back pixels, pixel 5 = R200/G180/B150, others = 10/20/30 -> ale_done rises 2 edges after pixel 7; A=200/180/150; dark_max=150.
REQ-029: Pixels 2 and 6 both have dark value 120 (2=130/120/140, 6=120/125/200), all others are lower -> A=130/120/140 (first wins).
REQ-030: All pixels 0/0/0 -> dark_max=0, A=1/1/1, ale_done=1.
REQ-031: Same frame with input_is_valid deasserted for 3 cycles after pixels 1 and 4 -> same A as REQ-028; ale_done 2 edges after last accepted pixel.
REQ-032: After DONE, feed 8 pixels of 255/255/255 -> A, dark_max and ale_done unchanged; then restart pulse coinciding with a valid pixel -> ale_done=0, and that pixel is not counted (8 further pixels are needed for done).
REQ-033: rst asserted after pixel 4 of a frame, then a full new frame with max at pixel 3 = 90/90/90 -> A=90/90/90; pre-reset pixels have no influence.

Source files
------------

// File: rtl/atm_light_estimator.sv
// -----------------------------------------------------------------------------
// atm_light_estimator
//
// Estimates the atmospheric light of one image frame for dark-channel-prior
// dehazing. Every accepted pixel has its dark channel min(R,G,B) computed.
// The RGB value of the first pixel holding the largest dark channel becomes
// the estimate. The estimate is floored to 1 per channel so that downstream
// division can never be by zero.
//
// Ports
//   clk            : clock, rising edge
//   rst            : synchronous, active-high reset
//   input_pixel    : 24-bit pixel, R=[23:16] G=[15:8] B=[7:0]
//   input_is_valid : pixel qualifier, sampled on every rising edge
//   restart        : single-cycle pulse; drops the frame and arms a new one
//   A_R/A_G/A_B    : registered atmospheric light estimate
//   dark_max       : registered largest dark channel of the frame (unfloored)
//   ale_done       : high while A_R/A_G/A_B hold the frame's final estimate
//   dbg_state_o    : current FSM state (IDLE=0, ACCUM=1, FLUSH=2, DONE=3)
//
// Handshake: input_is_valid has no back-pressure. A pixel is taken on every
// rising edge where input_is_valid is high, restart is low and the FSM is
// in IDLE or ACCUM. Pixels offered in FLUSH or DONE, or together with
// restart, are dropped.
// -----------------------------------------------------------------------------
module atm_light_estimator #(
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] input_pixel,
    input  logic        input_is_valid,
    input  logic        restart,
    output logic [7:0]  A_R,
    output logic [7:0]  A_G,
    output logic [7:0]  A_B,
    output logic [7:0]  dark_max,
    output logic        ale_done,
    output logic [1:0]  dbg_state_o
);

    localparam int N     = IMG_WIDTH * IMG_HEIGHT;
    localparam int CNT_W = ($clog2(N) > 18) ? $clog2(N) : 18;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;

    // Stage 1: registered pixel and its dark channel
    logic             s1_valid_q;
    logic [23:0]      s1_rgb_q;
    logic [7:0]       s1_dark_q;

    // Stage 2: running maximum and the RGB that produced it
    logic [7:0]       max_q;
    logic [23:0]      cand_q;

    // Output registers
    logic [7:0]       a_r_q;
    logic [7:0]       a_g_q;
    logic [7:0]       a_b_q;
    logic [7:0]       dark_max_q;
    logic             ale_done_q;

    logic             accept_d;
    logic [7:0]       rg_min_d;
    logic [7:0]       dark_d;

    function automatic logic [7:0] floor_one(input logic [7:0] v);
        return (v == 8'd0) ? 8'd1 : v;
    endfunction

    always_comb begin
        rg_min_d = (input_pixel[23:16] < input_pixel[15:8]) ? input_pixel[23:16]
                                                            : input_pixel[15:8];
        dark_d   = (rg_min_d < input_pixel[7:0]) ? rg_min_d : input_pixel[7:0];
        accept_d = input_is_valid && !restart &&
                   ((state_q == IDLE) || (state_q == ACCUM));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_rgb_q   <= '0;
            s1_dark_q  <= '0;
            max_q      <= '0;
            cand_q     <= '0;
            a_r_q      <= '0;
            a_g_q      <= '0;
            a_b_q      <= '0;
            dark_max_q <= '0;
            ale_done_q <= 1'b0;
        end else if (restart) begin
            // The estimate outputs are kept; only the frame state is cleared.
            state_q    <= IDLE;
            cnt_q      <= '0;
            s1_valid_q <= 1'b0;
            max_q      <= '0;
            cand_q     <= '0;
            ale_done_q <= 1'b0;
        end else begin
            // Stage 1. The valid flag follows acceptance. A gap lets stage 2
            // consume the held pixel exactly once, so no pixel is lost.
            s1_valid_q <= accept_d;
            if (accept_d) begin
                s1_rgb_q  <= input_pixel;
                s1_dark_q <= dark_d;
            end

            // Stage 2. A strictly-greater test keeps the earliest pixel on ties.
            if (s1_valid_q && (s1_dark_q > max_q)) begin
                max_q  <= s1_dark_q;
                cand_q <= s1_rgb_q;
            end

            case (state_q)
                IDLE, ACCUM: begin
                    if (accept_d) begin
                        if (cnt_q == LAST_IDX) begin
                            state_q <= FLUSH;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= ACCUM;
                            cnt_q   <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                FLUSH: begin
                    // Stage 2 absorbs the final pixel on this edge.
                    state_q <= DONE;
                end
                DONE: begin
                    // The output registers load on the first DONE edge.
                    // They then see the fully drained maximum. Later edges
                    // hold the values until restart or rst.
                    if (!ale_done_q) begin
                        a_r_q      <= floor_one(cand_q[23:16]);
                        a_g_q      <= floor_one(cand_q[15:8]);
                        a_b_q      <= floor_one(cand_q[7:0]);
                        dark_max_q <= max_q;
                        ale_done_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign A_R         = a_r_q;
    assign A_G         = a_g_q;
    assign A_B         = a_b_q;
    assign dark_max    = dark_max_q;
    assign ale_done    = ale_done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_atm_light_estimator.sv
module tb_atm_light_estimator;

  logic        clk;
  logic        rst;
  logic [23:0] input_pixel;
  logic        input_is_valid;
  logic        restart;
  logic [7:0]  A_R, A_G, A_B, dark_max;
  logic        ale_done;
  logic [1:0]  dbg_state_o;

  int checks;
  int errors;

  logic [31:0] exp_q[$];

  typedef struct packed {
    logic [7:0][23:0] px;
    logic [7:0]       ar, ag, ab, dm;
    logic [3:0]       gap;
  } vec_t;

  vec_t vecs [4];

  atm_light_estimator #(.IMG_WIDTH(4), .IMG_HEIGHT(2)) dut (
    .clk(clk), .rst(rst), .input_pixel(input_pixel),
    .input_is_valid(input_is_valid), .restart(restart),
    .A_R(A_R), .A_G(A_G), .A_B(A_B), .dark_max(dark_max),
    .ale_done(ale_done), .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {A_R, A_G, A_B, dark_max};
  endfunction

  // Reference: the first pixel with the largest min(R,G,B) wins, and its
  // channels are floored to 1.
  function automatic logic [31:0] model(input logic [7:0][23:0] px);
    int best;
    logic [23:0] cand;
    int r, g, b, d;
    best = 0;
    cand = 24'h0;
    for (int i = 0; i < 8; i++) begin
      r = int'(px[i][23:16]);
      g = int'(px[i][15:8]);
      b = int'(px[i][7:0]);
      d = r;
      if (g < d) d = g;
      if (b < d) d = b;
      if (d > best) begin
        best = d;
        cand = px[i];
      end
    end
    return {(cand[23:16] == 0) ? 8'd1 : cand[23:16],
            (cand[15:8]  == 0) ? 8'd1 : cand[15:8],
            (cand[7:0]   == 0) ? 8'd1 : cand[7:0],
            8'(best)};
  endfunction

  // ---------------- drivers ----------------
  task automatic send_px(input logic [23:0] p);
    input_pixel    = p;
    input_is_valid = 1'b1;
    step();
    input_is_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    input_is_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    step();
    restart = 1'b0;
  endtask

  // Sends a full frame. The given idle gap goes after pixels 1 and 4.
  task automatic run_frame(input logic [7:0][23:0] px, input int gap);
    for (int i = 0; i < 8; i++) begin
      send_px(px[i]);
      if ((i == 1 || i == 4) && gap > 0) idle(gap);
    end
  endtask

  // Called right after the edge that took the last pixel.
  task automatic check_latency(input string name, input logic [31:0] exp);
    step();
    check({name, "_done_e1"}, {31'd0, ale_done}, 32'd0);
    step();
    check({name, "_done_e2"}, {31'd0, ale_done}, 32'd1);
    check({name, "_outs"}, outs(), exp);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!ale_done && n < 20) begin
      step();
      n++;
    end
    check({name, "_done_seen"}, {31'd0, ale_done}, 32'd1);
  endtask

  logic [7:0][23:0] base_px, tie_px, zero_px, white_px, px;
  logic [31:0] exp_v, prev_v;

  initial begin
    checks         = 0;
    errors         = 0;
    rst            = 1'b0;
    restart        = 1'b0;
    input_is_valid = 1'b0;
    input_pixel    = 24'h0;

    // Stimulus tables.
    for (int i = 0; i < 8; i++) begin
      base_px[i]  = {8'd10, 8'd20, 8'd30};
      tie_px[i]   = {8'd50, 8'd60, 8'd70};
      zero_px[i]  = 24'h0;
      white_px[i] = 24'hFFFFFF;
    end
    base_px[5] = {8'd200, 8'd180, 8'd150};
    tie_px[2]  = {8'd130, 8'd120, 8'd140};
    tie_px[6]  = {8'd120, 8'd125, 8'd200};

    vecs[0] = '{px: base_px, ar: 8'd200, ag: 8'd180, ab: 8'd150, dm: 8'd150, gap: 4'd0};
    vecs[1] = '{px: tie_px,  ar: 8'd130, ag: 8'd120, ab: 8'd140, dm: 8'd120, gap: 4'd0};
    vecs[2] = '{px: zero_px, ar: 8'd1,   ag: 8'd1,   ab: 8'd1,   dm: 8'd0,   gap: 4'd0};
    vecs[3] = '{px: base_px, ar: 8'd200, ag: 8'd180, ab: 8'd150, dm: 8'd150, gap: 4'd3};

    // Reset state.
    do_reset();
    check("reset_outs", outs(), 32'd0);
    check("reset_done", {31'd0, ale_done}, 32'd0);
    check("reset_state", {30'd0, dbg_state_o}, 32'd0);

    // Table-driven directed frames.
    for (int v = 0; v < 4; v++) begin
      send_px(vecs[v].px[0]);
      check($sformatf("vec%0d_state_accum", v), {30'd0, dbg_state_o}, 32'd1);
      for (int i = 1; i < 8; i++) begin
        send_px(vecs[v].px[i]);
        if ((i == 1 || i == 4) && vecs[v].gap != 0) idle(int'(vecs[v].gap));
      end
      check_latency($sformatf("vec%0d", v),
                    {vecs[v].ar, vecs[v].ag, vecs[v].ab, vecs[v].dm});
      pulse_restart();
      check($sformatf("vec%0d_restart_done", v), {31'd0, ale_done}, 32'd0);
    end

    // Second pass in DONE is ignored. Restart with a pixel drops that pixel.
    run_frame(base_px, 0);
    check_latency("pass2", {8'd200, 8'd180, 8'd150, 8'd150});
    run_frame(white_px, 0);
    idle(2);
    check("pass2_hold_outs", outs(), {8'd200, 8'd180, 8'd150, 8'd150});
    check("pass2_hold_done", {31'd0, ale_done}, 32'd1);
    input_pixel    = 24'hFFFFFF;
    input_is_valid = 1'b1;
    restart        = 1'b1;
    step();
    restart        = 1'b0;
    input_is_valid = 1'b0;
    check("rs_done_low", {31'd0, ale_done}, 32'd0);
    check("rs_state_idle", {30'd0, dbg_state_o}, 32'd0);
    for (int i = 0; i < 7; i++) send_px(tie_px[i]);
    idle(4);
    check("rs_not_done_7", {31'd0, ale_done}, 32'd0);
    check("rs_outs_retained", outs(), {8'd200, 8'd180, 8'd150, 8'd150});
    send_px(tie_px[7]);
    check_latency("rs", {8'd130, 8'd120, 8'd140, 8'd120});

    // A reset in the middle of a frame abandons it.
    pulse_restart();
    for (int i = 0; i < 5; i++) send_px({8'd250, 8'd250, 8'd250});
    do_reset();
    check("midrst_outs", outs(), 32'd0);
    check("midrst_state", {30'd0, dbg_state_o}, 32'd0);
    px    = base_px;
    px[5] = {8'd10, 8'd20, 8'd30};
    px[3] = {8'd90, 8'd90, 8'd90};
    run_frame(px, 0);
    check_latency("midrst", {8'd90, 8'd90, 8'd90, 8'd90});
    pulse_restart();

    // Random frames with random gaps, checked against the reference model.
    for (int f = 0; f < 16; f++) begin
      for (int i = 0; i < 8; i++) begin
        if (f % 2 == 0)
          px[i] = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
        else
          px[i] = {8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)), 8'($urandom_range(0, 3))};
      end
      exp_q.push_back(model(px));
      prev_v = outs();
      for (int i = 0; i < 8; i++) begin
        send_px(px[i]);
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        if (i == 3) check($sformatf("rnd%0d_outs_hold", f), outs(), prev_v);
      end
      wait_done($sformatf("rnd%0d", f));
      exp_v = exp_q.pop_front();
      check($sformatf("rnd%0d_outs", f), outs(), exp_v);
      pulse_restart();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
